// File: rtl/seg7_scan_mux.sv
// ============================================================================
// seg7_scan_mux : scans four 7-segment patterns onto a shared bus with
//                 per-digit blanking and frame-synchronous shadow updates.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_mux #(
    parameter int         SCAN_DIV  = 50000,
    parameter int         BLANK_CYC = 500,
    parameter logic [6:0] SEG_OFF   = 7'h7F,
    parameter logic       AN_ON     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       en,
    input  logic [6:0] disp_0,
    input  logic [6:0] disp_1,
    input  logic [6:0] disp_2,
    input  logic [6:0] disp_3,
    input  logic       upd,
    output logic       upd_ack,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int             CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [3:0]     AN_OFF    = {4{~AN_ON}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    logic [3:0][6:0]  shadow_q, shadow_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             ack_q, ack_d;
    logic             tick_q, tick_d;
    logic             boundary;
    logic             capture;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        an_d      = AN_OFF;
        seg_d     = SEG_OFF;
        boundary  = 1'b0;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                    idx_d    = 2'd0;
                end
            end
            default: begin
                if (!en) begin
                    cnt_d = '0;
                    idx_d = 2'd0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        if (!en) begin
            state_d = S_IDLE;
        end else if (cnt_d < BLANK_END) begin
            state_d = S_BLANK;
        end else begin
            state_d = S_SHOW;
        end

        // Captures happen only where no digit can be mid-display: frame edge or idle.
        capture = (boundary || (state_q == S_IDLE)) && (pending_q || upd);
        if (capture) begin
            shadow_d  = {disp_3, disp_2, disp_1, disp_0};
            pending_d = 1'b0;
        end else if (upd) begin
            pending_d = 1'b1;
        end

        ack_d  = capture;
        tick_d = boundary;

        if (state_d == S_SHOW) begin
            an_d[idx_d] = AN_ON;
            seg_d       = shadow_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            pending_q <= 1'b0;
            shadow_q  <= {4{SEG_OFF}};
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            ack_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            ack_q     <= ack_d;
            tick_q    <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign upd_ack    = ack_q;
    assign frame_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
// ============================================================================
// tb_seg7_scan_mux : directed scenarios plus random traffic against a
//                    frame-position reference model.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_mux;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       en;
    logic [6:0] disp [4];
    logic       upd;
    logic       upd_ack;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: position inside the frame rather than slot counters.
    bit         m_run;
    int         m_t;
    bit         m_pend;
    logic [6:0] m_sh [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_ack;
    logic       e_tick;

    seg7_scan_mux #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .SEG_OFF   (7'h7F),
        .AN_ON     (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .en         (en),
        .disp_0     (disp[0]),
        .disp_1     (disp[1]),
        .disp_2     (disp[2]),
        .disp_3     (disp[3]),
        .upd        (upd),
        .upd_ack    (upd_ack),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        bit bnd;
        bit was_idle;
        bit cap;
        @(posedge clk);
        if (!rst_a) begin
            m_run  = 1'b0;
            m_t    = 0;
            m_pend = 1'b0;
            for (int i = 0; i < 4; i++) m_sh[i] = 7'h7F;
            e_ack  = 1'b0;
            e_tick = 1'b0;
        end else begin
            was_idle = !m_run;
            bnd      = en && (!m_run || m_t == FRAME - 1);
            if (!en) begin
                m_run = 1'b0;
                m_t   = 0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            cap = (was_idle || bnd) && (m_pend || upd);
            if (cap) begin
                for (int i = 0; i < 4; i++) m_sh[i] = disp[i];
                m_pend = 1'b0;
            end else if (upd) begin
                m_pend = 1'b1;
            end
            e_ack  = cap;
            e_tick = bnd;
        end
        if (m_run && (m_t % SCAN_DIV) >= BLANK_CYC) begin
            e_an  = 4'hF & ~(4'b0001 << (m_t / SCAN_DIV));
            e_seg = m_sh[m_t / SCAN_DIV];
        end else begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
        end
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("upd_ack", upd_ack, e_ack);
        chk("frame_tick", frame_tick, e_tick);
        chk("one_anode", ($countones(~an) <= 1), 1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        int guard = 0;
        while (m_t != pos && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        chk("align", m_t, pos);
    endtask

    initial begin
        rst_a = 1'b0;
        en    = 1'b1;
        upd   = 1'b1;
        for (int i = 0; i < 4; i++) disp[i] = 7'h55;
        run(3);

        // Idle capture then enable
        rst_a = 1'b1;
        en    = 1'b0;
        disp[0] = 7'h01; disp[1] = 7'h02; disp[2] = 7'h04; disp[3] = 7'h08;
        step();
        upd = 1'b0;
        step();
        en = 1'b1;
        run(40);

        // Mid-slot-1 update must wait for the frame boundary
        run_to(10);
        for (int i = 0; i < 4; i++) disp[i] = 7'h10;
        upd = 1'b1;
        step();
        upd = 1'b0;
        run(70);

        // Update presented exactly at the boundary edge
        run_to(FRAME - 1);
        for (int i = 0; i < 4; i++) disp[i] = 7'h20 + 7'(i);
        upd = 1'b1;
        step();
        upd = 1'b0;
        run(40);

        // Disable during slot-2 display, then re-enable
        run_to(20);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(20);

        // Pending update discarded by reset
        run_to(5);
        for (int i = 0; i < 4; i++) disp[i] = 7'h33;
        upd = 1'b1;
        step();
        upd = 1'b0;
        run(3);
        rst_a = 1'b0;
        run(2);
        rst_a = 1'b1;
        run(40);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_a = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            upd = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 4; i++) disp[i] = 7'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
